// File: rtl/otter_mdu.sv
// RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide; latency XLEN+1, or 1 for x/0, overflow
// and (with OTTER_MDU_FAST_MUL_EN) multiplies. i_ready=0 holds o_valid/o_result.
module otter_mdu #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_func,
    input  logic [XLEN-1:0] i_src_a,
    input  logic [XLEN-1:0] i_src_b,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [XLEN-1:0]  MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN-1);

    state_t            state_q, state_d;
    logic [2:0]        func_q, func_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              neg_q, neg_d;
    logic              rneg_q, rneg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              a_signed, b_signed, a_neg, b_neg;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   a_mag, b_mag;

    always_comb begin
        a_signed = !((i_func == 3'b011) || (i_func == 3'b101) || (i_func == 3'b111));
        b_signed = (i_func == 3'b000) || (i_func == 3'b001) ||
                   (i_func == 3'b100) || (i_func == 3'b110);
        a_neg    = a_signed & i_src_a[XLEN-1];
        b_neg    = b_signed & i_src_b[XLEN-1];
        a_mag    = a_neg ? (-i_src_a) : i_src_a;
        b_mag    = b_neg ? (-i_src_b) : i_src_b;
        div_zero = i_func[2] && (i_src_b == '0);
        div_ovf  = i_func[2] && !i_func[0] && (i_src_a == MIN_VAL) && (i_src_b == '1);
    end

    // hi holds the running product top / partial remainder; lo holds the multiplier / dividend.
    logic [XLEN:0]     mul_sum, rem_sh;
    logic              rem_ge;
    logic [XLEN-1:0]   rem_sub, it_hi, it_lo;
    logic [2*XLEN-1:0] prod_n, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, calc_res;

    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        rem_sh  = {hi_q, lo_q[XLEN-1]};
        rem_ge  = rem_sh >= {1'b0, b_q};
        rem_sub = rem_sh[XLEN-1:0] - b_q;
        if (func_q[2]) begin
            it_hi = rem_ge ? rem_sub : rem_sh[XLEN-1:0];
            it_lo = {lo_q[XLEN-2:0], rem_ge};
        end else begin
            it_hi = mul_sum[XLEN:1];
            it_lo = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        prod_n = {it_hi, it_lo};
        prod_s = neg_q ? (-prod_n) : prod_n;
        quo_s  = neg_q ? (-it_lo) : it_lo;
        rem_s  = rneg_q ? (-it_hi) : it_hi;
        if (func_q[2]) begin
            calc_res = func_q[1] ? rem_s : quo_s;
        end else begin
            calc_res = (func_q == 3'b000) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        end
    end

`ifdef OTTER_MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    logic [XLEN-1:0]   fast_res;

    always_comb begin
        fast_prod = {{XLEN{a_signed & i_src_a[XLEN-1]}}, i_src_a} *
                    {{XLEN{b_signed & i_src_b[XLEN-1]}}, i_src_b};
        fast_res  = (i_func == 3'b000) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`endif

    always_comb begin
        state_d  = state_q;
        func_d   = func_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    func_d = i_func;
                    hi_d   = '0;
                    lo_d   = a_mag;
                    b_d    = b_mag;
                    neg_d  = a_neg ^ b_neg;
                    rneg_d = a_neg;
                    cnt_d  = '0;
                    if (div_zero) begin
                        result_d = i_func[1] ? i_src_a : '1;
                        state_d  = S_DONE;
                    end else if (div_ovf) begin
                        result_d = i_func[1] ? '0 : MIN_VAL;
                        state_d  = S_DONE;
`ifdef OTTER_MDU_FAST_MUL_EN
                    end else if (!i_func[2]) begin
                        result_d = fast_res;
                        state_d  = S_DONE;
`endif
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                hi_d  = it_hi;
                lo_d  = it_lo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    result_d = calc_res;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (i_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            func_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            func_q   <= func_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign o_ready  = (state_q == S_IDLE);
    assign o_valid  = (state_q == S_DONE);
    assign o_result = result_q;

endmodule

// File: tb/tb_otter_mdu.sv
// Bench for otter_mdu (XLEN=32): RV32M reference model checked every cycle plus literal directed vectors.
module tb_otter_mdu;

    localparam logic [2:0] F_MUL = 3'd0, F_MULH = 3'd1, F_MULHSU = 3'd2, F_MULHU = 3'd3;
    localparam logic [2:0] F_DIV = 3'd4, F_DIVU = 3'd5, F_REM = 3'd6, F_REMU = 3'd7;
`ifdef OTTER_MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [2:0]  i_func = 3'd0;
    logic [31:0] i_src_a = 32'd0;
    logic [31:0] i_src_b = 32'd0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [31:0] o_result;

    int checks = 0;
    int errors = 0;

    otter_mdu #(.XLEN(32)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_func   (i_func),
        .i_src_a  (i_src_a),
        .i_src_b  (i_src_b),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint p;
        logic [63:0] u;
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        case (f)
            F_MUL:    begin u = 64'(a) * 64'(b); return u[31:0]; end
            F_MULH:   begin p = longint'(sa) * longint'(sb); return p[63:32]; end
            F_MULHSU: begin p = longint'(sa) * longint'({32'd0, b}); return p[63:32]; end
            F_MULHU:  begin u = 64'(a) * 64'(b); return u[63:32]; end
            F_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            F_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            F_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default:  return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (!f[2]) return MUL_LAT;
        if (b == 0) return 1;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Transaction-level model: one request in flight, valid after its latency, handed off on i_ready.
    int          cyc = 0;
    int          acc_cyc = 0;
    int          acc_cnt = 0;
    bit          in_flight = 0;
    int          exp_lat = 0;
    logic [31:0] exp_res = 0;
    bit          exp_v;

    always @(negedge i_clk) begin
        cyc++;
        if (i_rst) begin
            chk("rst_o_valid", 32'(o_valid), 32'd0);
            chk("rst_o_ready", 32'(o_ready), 32'd1);
            in_flight = 0;
        end else begin
            exp_v = in_flight && ((cyc - acc_cyc) >= exp_lat);
            chk("o_ready", 32'(o_ready), 32'(!in_flight));
            chk("o_valid", 32'(o_valid), 32'(exp_v));
            if (o_valid && exp_v) chk("o_result", o_result, exp_res);
            if (exp_v && i_ready) begin
                in_flight = 0;
            end else if (!in_flight && i_valid && o_ready) begin
                in_flight = 1;
                acc_cyc   = cyc;
                acc_cnt++;
                exp_res   = ref_res(i_func, i_src_a, i_src_b);
                exp_lat   = ref_lat(i_func, i_src_a, i_src_b);
            end
        end
    end

    // Issues one op, scrambles the inputs after acceptance, checks result and latency against literals.
    task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat);
        int n;
        @(posedge i_clk); #1;
        i_valid = 1'b1; i_func = f; i_src_a = a; i_src_b = b;
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_func = 3'($urandom); i_src_a = $urandom; i_src_b = $urandom;
        n = 0;
        while (!o_valid && n < 100) begin
            @(negedge i_clk);
            if (!o_valid) n++;
        end
        if (!o_valid) begin
            chk({nm, "_timeout"}, 32'(o_valid), 32'd1);
        end else begin
            chk(nm, o_result, exp);
            chk({nm, "_lat"}, 32'(n + 1), 32'(lat));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, start;
        logic [31:0] held;
        repeat (3) @(posedge i_clk);
        #1;
        chk("reset_o_valid", 32'(o_valid), 32'd0);
        chk("reset_o_ready", 32'(o_ready), 32'd1);
        chk("reset_o_result", o_result, 32'd0);
        i_rst = 1'b0;

        run_op("mul",    F_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
        run_op("mulh",   F_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MUL_LAT);
        run_op("mulhu",  F_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        run_op("mulhsu", F_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
        run_op("mul0",   F_MUL,    32'h1234_5678,  32'd0,         32'd0,         MUL_LAT);
        run_op("div",    F_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33);
        run_op("rem",    F_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33);
        run_op("divu",   F_DIVU,   32'd100,        32'd7,         32'd14,        33);
        run_op("remu",   F_REMU,   32'd100,        32'd7,         32'd2,         33);
        run_op("div0",   F_DIV,    32'h1234_5678,  32'd0,         32'hFFFF_FFFF, 1);
        run_op("remu0",  F_REMU,   32'h1234_5678,  32'd0,         32'h1234_5678, 1);
        run_op("divovf", F_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("removf", F_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);

        // Backpressure: result held, no second accept while DONE.
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        run_op("bp_mulhu", F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        held = o_result;
        for (int k = 0; k < 5; k++) begin
            @(posedge i_clk); #1;
            i_valid = 1'b1; i_func = 3'($urandom); i_src_a = $urandom; i_src_b = $urandom;
            @(negedge i_clk);
            chk("bp_o_valid", 32'(o_valid), 32'd1);
            chk("bp_o_result", o_result, 32'hFFFF_FFFE);
            chk("bp_o_ready", 32'(o_ready), 32'd0);
        end
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        chk("bp_release_o_ready", 32'(o_ready), 32'd1);
        chk("bp_release_o_valid", 32'(o_valid), 32'd0);

        // Reset in the middle of a divide.
        @(posedge i_clk); #1;
        i_valid = 1'b1; i_func = F_DIVU; i_src_a = 32'd1000; i_src_b = 32'd3;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (10) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        #1;
        chk("midrst_o_valid", 32'(o_valid), 32'd0);
        chk("midrst_o_ready", 32'(o_ready), 32'd1);
        chk("midrst_o_result", o_result, 32'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        run_op("post_rst_divu", F_DIVU, 32'd1000, 32'd3, 32'd333, 33);

        // Back-to-back: i_valid held high with operands changing every cycle.
        @(posedge i_clk); #1;
        start = acc_cnt;
        n = 0;
        i_valid = 1'b1;
        while (acc_cnt < start + 10 && n < 2000) begin
            i_func  = 3'($urandom);
            i_src_a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0:       i_src_b = 32'd0;
                1:       i_src_b = 32'hFFFF_FFFF;
                2:       i_src_b = $urandom_range(1, 20);
                default: i_src_b = $urandom;
            endcase
            @(posedge i_clk); #1;
            n++;
        end
        i_valid = 1'b0;
        chk("b2b_accepts", 32'(acc_cnt - start), 32'd10);
        n = 0;
        while (in_flight && n < 100) begin
            @(posedge i_clk); #1;
            n++;
        end
        chk("b2b_drain", 32'(in_flight), 32'd0);
        repeat (2) @(posedge i_clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/otter_mdu.md
Name: otter_mdu

Overview:
- Parametrised iterative multiply/divide unit implementing the RV32M operation set alongside the single-cycle ALU.
- Sits in the execute stage. Accepts one operation per valid/ready handshake and returns a registered result through an output valid/ready handshake.
- Multiply uses radix-2 shift-add; divide uses restoring shift-subtract. Signed ops run on operand magnitudes and fix the sign at the end.

Parameters:
- XLEN, 32, operand/result width; must be even, 8 or more.
- CNT_W, $clog2(XLEN), iteration counter width (derived; not overridden).

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  asynchronous active-high reset.
- i_valid  in  1  request valid.
- o_ready  out  1  unit can accept a request (high only in IDLE).
- i_func  in  3  funct3 code: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- i_src_a  in  XLEN  rs1 operand / dividend.
- i_src_b  in  XLEN  rs2 operand / divisor.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts result.
- o_result  out  XLEN  result, held stable while o_valid=1.

Behaviour:
- Clocking and reset:
  - Single clock, i_clk.
  - Reset is asynchronous and active-high on i_rst: state=IDLE, o_ready=1, o_valid=0, o_result=0, counter and datapath registers 0.
  - Reset mid-operation abandons the operation with no result produced.
- States: IDLE, CALC, DONE.
- IDLE:
  - o_ready=1.
  - When i_valid=1, latch func/operands (accept cycle T).
  - Div-by-zero or signed overflow goes straight to DONE; everything else goes to CALC with counter=0.
- CALC:
  - One iteration per cycle; counter increments.
  - When counter==XLEN-1, apply sign correction and select the result, then go to DONE.
  - o_ready=0 throughout CALC; i_valid is ignored.
- DONE:
  - o_valid=1 and o_result is registered.
  - On i_ready=1, return to IDLE with o_valid=0 and o_ready=1 on the next cycle.
  - No new request is accepted in the same cycle as the result handoff.
- Latency:
  - Normal ops: o_valid is first seen XLEN+1 cycles after T (33 for XLEN=32).
  - Special divides: 1 cycle after T.
- Arithmetic:
  - Full 2*XLEN product. MUL returns the low half; MULH/MULHSU/MULHU return the high half.
  - MULHSU: src_a signed, src_b unsigned.
  - DIV/REM truncate toward zero; the remainder takes the sign of the dividend.
- Boundary cases:
  - Divisor 0: DIV/DIVU return all ones; REM/REMU return the dividend.
  - Signed overflow (src_a=MIN, src_b=-1): DIV returns MIN; REM returns 0.
  - Multiply by 0 has no special case and takes the full latency.
- Backpressure: i_ready=0 in DONE holds o_valid and o_result indefinitely.
- i_func, i_src_a and i_src_b are sampled only at acceptance; later changes have no effect.

Optional Feature:
- OTTER_MDU_FAST_MUL_EN.
- Defined:
  - Multiply ops compute the 2*XLEN product combinationally at acceptance and go IDLE->DONE, giving 1-cycle latency.
  - Divide ops are unchanged.
- Undefined: multiply is iterative, with XLEN+1 cycle latency.
- Results are identical either way.

Test Plan:
- MUL 7 x 0xFFFFFFFD -> 0xFFFFFFEB; MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF. Each with o_valid 33 cycles after accept (1 with OTTER_MDU_FAST_MUL_EN).
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
- DIV 0x12345678 / 0 -> 0xFFFFFFFF and REMU 0x12345678 / 0 -> 0x12345678, each valid 1 cycle after accept; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM same operands -> 0, 1 cycle.
- Backpressure: hold i_ready=0 for 5 cycles after o_valid with i_valid=1 and changing operands -> o_valid/o_result stable, o_ready=0, no second accept. Release i_ready -> o_ready=1 next cycle.
- Reset mid-op: assert i_rst 10 cycles into DIVU 1000 / 3 -> o_valid=0, o_ready=1, o_result=0 immediately. A following DIVU 1000 / 3 -> 333 with full latency.
- Back-to-back: ten random ops issued with i_valid held high and i_ready=1 -> each result matches the reference model, with exactly one accept per IDLE visit.
